// File: rtl/iomem_gpio_pkg.sv
// Shared constants for the iomem GPIO block: register word offsets, default
// decode base and the interrupt-polarity reset value.
package iomem_gpio_pkg;

    localparam logic [7:0] GPIO_DEFAULT_BASE = 8'h03;

    // Register selectors as word indices, compared against iomem_addr[7:2]
    localparam logic [5:0] GPIO_REG_DATA_OUT   = 6'd0;
    localparam logic [5:0] GPIO_REG_DIR        = 6'd1;
    localparam logic [5:0] GPIO_REG_DATA_IN    = 6'd2;
    localparam logic [5:0] GPIO_REG_IRQ_EN     = 6'd3;
    localparam logic [5:0] GPIO_REG_IRQ_POL    = 6'd4;
    localparam logic [5:0] GPIO_REG_IRQ_STATUS = 6'd5;

    localparam logic [31:0] GPIO_IRQ_POL_RESET = 32'hFFFF_FFFF;

    function automatic logic [31:0] byte_mask(input logic [3:0] wstrb);
        return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-pin two-flop synchroniser; with IOMEM_GPIO_IRQ_EN defined it adds a
// history flop and a polarity-selected edge event vector.
module gpio_sync_edge #(
    parameter int NGPIO = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [NGPIO-1:0] pins,
    output logic [NGPIO-1:0] level
`ifdef IOMEM_GPIO_IRQ_EN
    ,
    input  logic [NGPIO-1:0] pol,
    output logic [NGPIO-1:0] events
`endif
);

    logic [NGPIO-1:0] s1_r;
    logic [NGPIO-1:0] s2_r;

    // Metastability filter on the asynchronous pin inputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_r <= {NGPIO{1'b0}};
            s2_r <= {NGPIO{1'b0}};
        end else begin
            s1_r <= pins;
            s2_r <= s1_r;
        end
    end

    assign level = s2_r;

`ifdef IOMEM_GPIO_IRQ_EN
    logic [NGPIO-1:0] prev_r;

    // History of the synchronised level, one cycle behind s2
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_r <= {NGPIO{1'b0}};
        end else begin
            prev_r <= s2_r;
        end
    end

    // pol=1 selects rising edges, pol=0 falling edges
    assign events = (pol & s2_r & ~prev_r) | (~pol & ~s2_r & prev_r);
`endif

endmodule

// File: rtl/iomem_gpio.sv
// NGPIO-pin GPIO peripheral on the PicoSoC iomem bus. Edge-detect interrupt
// registers are built only when IOMEM_GPIO_IRQ_EN is defined.
module iomem_gpio
    import iomem_gpio_pkg::*;
#(
    parameter int         NGPIO     = 32,
    parameter logic [7:0] BASE_ADDR = GPIO_DEFAULT_BASE
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    output logic [NGPIO-1:0] gpio_o,
    output logic [NGPIO-1:0] gpio_oe,
    input  logic [NGPIO-1:0] gpio_i,
    output logic             irq
);

    logic             ready_r;
    logic [31:0]      rdata_r;
    logic             accept_s;
    logic             wr_s;
    logic [5:0]       sel_s;
    logic [31:0]      wmask_full_s;
    logic [NGPIO-1:0] wmask_s;
    logic [NGPIO-1:0] wbits_s;
    logic [NGPIO-1:0] out_r;
    logic [NGPIO-1:0] dir_r;
    logic [NGPIO-1:0] level_s;
    logic [31:0]      rd_s;
    logic             unused_s;

    // The !ready_r term limits the bus to one access every two cycles
    assign accept_s     = iomem_valid && !ready_r && (iomem_addr[31:24] == BASE_ADDR);
    assign wr_s         = accept_s && (iomem_wstrb != 4'b0000);
    assign sel_s        = iomem_addr[7:2];
    assign wmask_full_s = byte_mask(iomem_wstrb);
    assign wmask_s      = wmask_full_s[NGPIO-1:0];
    assign wbits_s      = iomem_wdata[NGPIO-1:0] & wmask_s;
    assign unused_s     = ^{iomem_addr[23:8], iomem_addr[1:0], iomem_wdata, wmask_full_s};

`ifdef IOMEM_GPIO_IRQ_EN
    logic [NGPIO-1:0] en_r;
    logic [NGPIO-1:0] pol_r;
    logic [NGPIO-1:0] status_r;
    logic [NGPIO-1:0] events_s;
    logic [NGPIO-1:0] clr_s;

    gpio_sync_edge #(.NGPIO(NGPIO)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .pins   (gpio_i),
        .level  (level_s),
        .pol    (pol_r),
        .events (events_s)
    );

    assign clr_s = (wr_s && (sel_s == GPIO_REG_IRQ_STATUS)) ? wbits_s : {NGPIO{1'b0}};

    // Interrupt control registers; a set in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (!resetn) begin
            en_r     <= {NGPIO{1'b0}};
            pol_r    <= GPIO_IRQ_POL_RESET[NGPIO-1:0];
            status_r <= {NGPIO{1'b0}};
        end else begin
            if (wr_s && (sel_s == GPIO_REG_IRQ_EN)) begin
                en_r <= (en_r & ~wmask_s) | wbits_s;
            end
            if (wr_s && (sel_s == GPIO_REG_IRQ_POL)) begin
                pol_r <= (pol_r & ~wmask_s) | wbits_s;
            end
            status_r <= (status_r & ~clr_s) | (events_s & en_r);
        end
    end

    assign irq = |(status_r & en_r);
`else
    gpio_sync_edge #(.NGPIO(NGPIO)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .pins   (gpio_i),
        .level  (level_s)
    );

    assign irq = 1'b0;
`endif

    // Pin output value and direction registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_r <= {NGPIO{1'b0}};
            dir_r <= {NGPIO{1'b0}};
        end else begin
            if (wr_s && (sel_s == GPIO_REG_DATA_OUT)) begin
                out_r <= (out_r & ~wmask_s) | wbits_s;
            end
            if (wr_s && (sel_s == GPIO_REG_DIR)) begin
                dir_r <= (dir_r & ~wmask_s) | wbits_s;
            end
        end
    end

    // Read mux over pre-write register values; unimplemented bits read 0
    always_comb begin
        rd_s = 32'd0;
        case (sel_s)
            GPIO_REG_DATA_OUT:   rd_s[NGPIO-1:0] = out_r;
            GPIO_REG_DIR:        rd_s[NGPIO-1:0] = dir_r;
            GPIO_REG_DATA_IN:    rd_s[NGPIO-1:0] = level_s;
`ifdef IOMEM_GPIO_IRQ_EN
            GPIO_REG_IRQ_EN:     rd_s[NGPIO-1:0] = en_r;
            GPIO_REG_IRQ_POL:    rd_s[NGPIO-1:0] = pol_r;
            GPIO_REG_IRQ_STATUS: rd_s[NGPIO-1:0] = status_r;
`endif
            default:             rd_s = 32'd0;
        endcase
    end

    // One-cycle ready pulse; rdata is zero outside it so peripherals can be ORed
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_r <= 1'b0;
            rdata_r <= 32'd0;
        end else if (accept_s) begin
            ready_r <= 1'b1;
            rdata_r <= rd_s;
        end else begin
            ready_r <= 1'b0;
            rdata_r <= 32'd0;
        end
    end

    assign iomem_ready = ready_r;
    assign iomem_rdata = rdata_r;
    assign gpio_o      = out_r;
    assign gpio_oe     = dir_r;

endmodule

// File: tb/tb_iomem_gpio.sv
// Randomised bench for iomem_gpio: a 32-pin instance checked against a
// register-level model, plus an 8-pin instance for the width boundary.
module tb_iomem_gpio;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid_a, valid_b;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        ready_a, ready_b, irq_a, irq_b;
    logic [31:0] rdata_a, rdata_b;
    logic [31:0] gpio_o_a, gpio_oe_a, gpio_i_a;
    logic [7:0]  gpio_o_b, gpio_oe_b, gpio_i_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_out, m_dir, m_en, m_pol, m_status, m_pins;

    always #5 clk = ~clk;

    iomem_gpio #(.NGPIO(32), .BASE_ADDR(8'h03)) dut_a (
        .clk(clk), .resetn(resetn), .iomem_valid(valid_a), .iomem_ready(ready_a),
        .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata_a),
        .gpio_o(gpio_o_a), .gpio_oe(gpio_oe_a), .gpio_i(gpio_i_a), .irq(irq_a)
    );

    iomem_gpio #(.NGPIO(8), .BASE_ADDR(8'h03)) dut_b (
        .clk(clk), .resetn(resetn), .iomem_valid(valid_b), .iomem_ready(ready_b),
        .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata_b),
        .gpio_o(gpio_o_b), .gpio_oe(gpio_oe_b), .gpio_i(gpio_i_b), .irq(irq_b)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ra(input int idx);
        return 32'h0300_0000 | (32'(idx) << 2);
    endfunction

    function automatic void m_reset();
        m_out = 32'd0; m_dir = 32'd0; m_en = 32'd0;
        m_pol = 32'hFFFF_FFFF; m_status = 32'd0;
    endfunction

    function automatic logic [31:0] mread(input int idx);
        case (idx)
            0: return m_out;
            1: return m_dir;
            2: return m_pins;
`ifdef IOMEM_GPIO_IRQ_EN
            3: return m_en;
            4: return m_pol;
            5: return m_status;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic void mwrite(input int idx, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] bm;
        bm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        case (idx)
            0: m_out = (m_out & ~bm) | (d & bm);
            1: m_dir = (m_dir & ~bm) | (d & bm);
            3: m_en  = (m_en & ~bm) | (d & bm);
            4: m_pol = (m_pol & ~bm) | (d & bm);
            5: m_status = m_status & ~(d & bm);
            default: ;
        endcase
    endfunction

    // Pins settled to v: latch interrupt events by the rising/falling rule
    function automatic void model_pins(input logic [31:0] v);
        logic [31:0] rise, fall;
        rise = v & ~m_pins;
        fall = ~v & m_pins;
        m_status = m_status | (((rise & m_pol) | (fall & ~m_pol)) & m_en);
        m_pins = v;
    endfunction

    function automatic logic mirq();
`ifdef IOMEM_GPIO_IRQ_EN
        return |(m_status & m_en);
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- bus driver ----------------
    task automatic bus(input bit sel, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output bit ok);
        addr = a; wdata = d; wstrb = s;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        ok = 1'b0; rd = 32'd0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if ((sel ? ready_b : ready_a) === 1'b1) begin
                ok = 1'b1;
                rd = sel ? rdata_b : rdata_a;
                break;
            end
        end
        valid_a = 1'b0; valid_b = 1'b0;
    endtask

    task automatic mbus(input int idx, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd; bit ok;
        bus(1'b0, ra(idx), d, s, rd, ok);
        checks++;
        if (!ok || rd !== mread(idx)) begin
            errors++;
            $display("FAIL bus reg%0d: ok=%0d got %h expected %h", idx, ok, rd, mread(idx));
        end
        mwrite(idx, d, s);
    endtask

    task automatic set_pins(input logic [31:0] v);
        gpio_i_a = v;
        repeat (4) @(posedge clk);
        #1;
        model_pins(v);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ready_a, irq_a, rdata_a, gpio_o_a, gpio_oe_a} !== 98'd0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b irq=%b rdata=%h o=%h oe=%h expected all 0",
                     ready_a, irq_a, rdata_a, gpio_o_a, gpio_oe_a);
        end
        resetn = 1'b1;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int idx = 0; idx < 8; idx++) mbus(idx, 32'd0, 4'b0000);
    endtask

    task automatic test_write();
        logic [31:0] rd; bit ok;
        bus(1'b0, 32'h0300_0000, 32'h0000_00A5, 4'b0001, rd, ok);
        mwrite(0, 32'h0000_00A5, 4'b0001);
        checks++;
        if (!ok || gpio_o_a !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL write_a5: ok=%0d gpio_o %h expected 000000a5", ok, gpio_o_a);
        end
        @(posedge clk); #1;
        checks++;
        if (ready_a !== 1'b0 || rdata_a !== 32'd0) begin
            errors++;
            $display("FAIL ready_pulse: ready=%b rdata=%h expected 0/00000000", ready_a, rdata_a);
        end
        mbus(0, 32'd0, 4'b0000);
        mbus(0, 32'hFFFF_FFFF, 4'b0100);
        checks++;
        if (gpio_o_a !== 32'h00FF_00A5) begin
            errors++;
            $display("FAIL byte_mask: gpio_o %h expected 00ff00a5", gpio_o_a);
        end
        mbus(0, 32'h1234_5678, 4'b1111);
        mbus(0, 32'd0, 4'b0000);
    endtask

    task automatic test_ngpio8();
        logic [31:0] rd; bit ok;
        bus(1'b1, 32'h0300_0004, 32'hFFFF_FFFF, 4'b1111, rd, ok);
        checks++;
        if (!ok || gpio_oe_b !== 8'hFF) begin
            errors++;
            $display("FAIL n8_dir: ok=%0d gpio_oe %h expected ff", ok, gpio_oe_b);
        end
        bus(1'b1, 32'h0300_0004, 32'd0, 4'b0000, rd, ok);
        checks++;
        if (!ok || rd !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL n8_dir_read: got %h expected 000000ff", rd);
        end
        bus(1'b0, 32'h0400_0000, 32'hFFFF_FFFF, 4'b1111, rd, ok);
        checks++;
        if (ok || gpio_o_a !== m_out) begin
            errors++;
            $display("FAIL foreign_addr: ready_seen=%0d gpio_o %h expected no ready, %h", ok, gpio_o_a, m_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq;
        addr = ra(1); wstrb = 4'b0000; wdata = 32'd0; valid_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seq[3-i] = ready_a;
        end
        valid_a = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (seq !== 4'b1010) begin
            errors++;
            $display("FAIL back_to_back: ready seq %b expected 1010", seq);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            int idx;
            if ($urandom_range(0, 3) == 0) begin
                set_pins($urandom);
                checks++;
                if (irq_a !== mirq()) begin
                    errors++;
                    $display("FAIL rand_irq_pins: got %b expected %b", irq_a, mirq());
                end
            end
            idx = $urandom_range(0, 7);
            mbus(idx, $urandom, 4'($urandom_range(0, 15)));
            checks++;
            if (gpio_o_a !== m_out || gpio_oe_a !== m_dir || irq_a !== mirq()) begin
                errors++;
                $display("FAIL rand_outputs: o=%h oe=%h irq=%b expected %h %h %b",
                         gpio_o_a, gpio_oe_a, irq_a, m_out, m_dir, mirq());
            end
        end
        for (int idx = 0; idx < 6; idx++) mbus(idx, 32'd0, 4'b0000);
    endtask

    task automatic test_edge_irq();
        mbus(4, 32'hFFFF_FFFF, 4'b1111);
        mbus(3, 32'h0000_0008, 4'b1111);
        set_pins(32'd0);
        mbus(5, 32'hFFFF_FFFF, 4'b1111);
        gpio_i_a = 32'h0000_0008;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (irq_a !== 1'b0) begin
            errors++;
            $display("FAIL irq_early: got %b expected 0", irq_a);
        end
        @(posedge clk); #1;
        model_pins(32'h0000_0008);
        checks++;
        if (irq_a !== mirq()) begin
            errors++;
            $display("FAIL irq_rise: got %b expected %b", irq_a, mirq());
        end
        mbus(2, 32'd0, 4'b0000);
        mbus(5, 32'd0, 4'b0000);
    endtask

    task automatic test_w1c();
        mbus(3, 32'h0000_0001, 4'b1111);
        mbus(4, 32'hFFFF_FFFE, 4'b1111);
        set_pins(32'h0000_0001);
        mbus(5, 32'hFFFF_FFFF, 4'b1111);
        set_pins(32'h0000_0000);
        checks++;
        if (irq_a !== mirq()) begin
            errors++;
            $display("FAIL irq_fall: got %b expected %b", irq_a, mirq());
        end
        mbus(5, 32'h0000_0001, 4'b0001);
        checks++;
        if (irq_a !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: got %b expected 0", irq_a);
        end
        set_pins(32'h0000_0001);
        gpio_i_a = 32'h0000_0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mbus(5, 32'h0000_0001, 4'b0001);
        model_pins(32'h0000_0000);
        mbus(5, 32'd0, 4'b0000);
        checks++;
        if (irq_a !== mirq()) begin
            errors++;
            $display("FAIL set_wins_irq: got %b expected %b", irq_a, mirq());
        end
    endtask

`ifndef IOMEM_GPIO_IRQ_EN
    task automatic test_irq_disabled();
        mbus(3, 32'hFFFF_FFFF, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            set_pins(~m_pins);
            checks++;
            if (irq_a !== 1'b0) begin
                errors++;
                $display("FAIL no_irq_build: irq %b expected 0", irq_a);
            end
        end
        for (int idx = 3; idx < 6; idx++) mbus(idx, 32'd0, 4'b0000);
    endtask
`endif

    task automatic test_reset_mid();
        mbus(1, 32'h0000_00FF, 4'b1111);
        mbus(0, 32'h0000_0F0F, 4'b1111);
        addr = ra(1); wstrb = 4'b0000; valid_a = 1'b1;
        resetn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ready_a, irq_a, gpio_oe_a, gpio_o_a} !== 66'd0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b irq=%b oe=%h o=%h expected all 0",
                     ready_a, irq_a, gpio_oe_a, gpio_o_a);
        end
        valid_a = 1'b0;
        resetn = 1'b1;
        m_reset();
        repeat (4) @(posedge clk);
        #1;
        for (int idx = 0; idx < 6; idx++) mbus(idx, 32'd0, 4'b0000);
    endtask

    initial begin
        resetn = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        wstrb = 4'b0000; addr = 32'd0; wdata = 32'd0;
        gpio_i_a = 32'd0; gpio_i_b = 8'd0; m_pins = 32'd0;
        m_reset();
        test_reset();
        test_write();
        test_ngpio8();
        test_back_to_back();
        test_random();
        test_edge_irq();
        test_w1c();
`ifndef IOMEM_GPIO_IRQ_EN
        test_irq_disabled();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
